// File: rtl/demux_pipeline.sv
// Pipelined 1-to-N demultiplexer. The select is decoded MSB-first over LATENCY register levels.
// Build option: define DEMUX_PIPELINE_DROP_COUNT_EN to add a saturating drop_count port.
module demux_pipeline #(
   parameter int WIDTH        = 1,
   parameter int OUTPUT_COUNT = 2,
   parameter int LATENCY      = 1,
   localparam int SEL_W       = (OUTPUT_COUNT > 1) ? $clog2(OUTPUT_COUNT) : 1,
   localparam int SEL_CHUNK   = ((SEL_W + LATENCY - 1) / LATENCY > 1) ?
                                (SEL_W + LATENCY - 1) / LATENCY : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [SEL_W-1:0]              sel,
   input  logic [WIDTH-1:0]              in,
   output logic [WIDTH*OUTPUT_COUNT-1:0] out,
   output logic [OUTPUT_COUNT-1:0]       out_valid
`ifdef DEMUX_PIPELINE_DROP_COUNT_EN
   ,
   output logic [15:0]                   drop_count
`endif
);

   localparam logic [SEL_W-1:0] LAST = SEL_W'(OUTPUT_COUNT - 1);

   // Feed k is the input seen by level k: feed 0 is the port, feed k>0 is level k-1.
   logic             f_v    [LATENCY];
   logic [SEL_W-1:0] f_sel  [LATENCY];
   logic [WIDTH-1:0] f_data [LATENCY];
`ifdef DEMUX_PIPELINE_DROP_COUNT_EN
   logic             f_d    [LATENCY];
   assign f_d[0] = 1'b0;
`endif

   assign f_v[0]    = in_valid;
   assign f_sel[0]  = sel;
   assign f_data[0] = in;

   for (genvar s = 0; s < LATENCY - 1; s++) begin : g_lvl
      localparam int CONS  = ((s + 1) * SEL_CHUNK < SEL_W) ? (s + 1) * SEL_CHUNK : SEL_W;
      localparam int SHIFT = SEL_W - CONS;

      logic             in_rng;
      logic             v_q;
      logic [SEL_W-1:0] sel_q;
      logic [WIDTH-1:0] data_q;

      // A beat whose group prefix is past the last built group dies here.
      assign in_rng = (f_sel[s] >> SHIFT) <= (LAST >> SHIFT);

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= 1'b0;
         end else begin
            v_q <= f_v[s] & in_rng;
         end
         sel_q  <= f_sel[s];
         data_q <= f_data[s];
      end

`ifdef DEMUX_PIPELINE_DROP_COUNT_EN
      logic d_q;
      always_ff @(posedge clk) begin
         if (rst) begin
            d_q <= 1'b0;
         end else begin
            d_q <= f_d[s] | (f_v[s] & ~in_rng);
         end
      end
      assign f_d[s+1] = d_q;
`endif

      assign f_v[s+1]    = v_q;
      assign f_sel[s+1]  = sel_q;
      assign f_data[s+1] = data_q;
   end

   logic [OUTPUT_COUNT-1:0]       out_valid_d;
   logic [OUTPUT_COUNT-1:0]       out_valid_q;
   logic [WIDTH*OUTPUT_COUNT-1:0] out_q;

   always_comb begin
      out_valid_d = '0;
      for (int i = 0; i < OUTPUT_COUNT; i++) begin
         if (f_v[LATENCY-1] && (f_sel[LATENCY-1] == SEL_W'(i))) begin
            out_valid_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= '0;
         out_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         for (int i = 0; i < OUTPUT_COUNT; i++) begin
            if (out_valid_d[i]) begin
               out_q[i*WIDTH +: WIDTH] <= f_data[LATENCY-1];
            end
         end
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;

`ifdef DEMUX_PIPELINE_DROP_COUNT_EN
   logic        drop_at_out;
   logic [15:0] drop_cnt_q;

   // Counted at the edge where the beat would have reached its lane.
   assign drop_at_out = f_d[LATENCY-1] | (f_v[LATENCY-1] & (f_sel[LATENCY-1] > LAST));

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q <= 16'd0;
      end else if (drop_at_out && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_demux_pipeline.sv
// Scoreboard bench for demux_pipeline: stimulus pushes expected deliveries, a negedge monitor pops and compares.
module tb_demux_pipeline;
   localparam int W  = 4;
   localparam int OC = 10;
   localparam int L  = 2;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [SW-1:0] sel = '0;
   logic [W-1:0]  din = '0;
   logic [W*OC-1:0] dout;
   logic [OC-1:0]   ov;

   logic          v5 = 1'b0;
   logic [SW-1:0] sel5 = '0;
   logic [W-1:0]  din5 = '0;
   logic [W*OC-1:0] dout5;
   logic [OC-1:0]   ov5;

   logic          vb = 1'b0;
   logic [0:0]    selb = '0;
   logic [W-1:0]  dinb = '0;
   logic [W-1:0]  doutb;
   logic [0:0]    ovb;

`ifdef DEMUX_PIPELINE_DROP_COUNT_EN
   logic [15:0] dc, dc5, dcb;
`endif

   demux_pipeline #(.WIDTH(W), .OUTPUT_COUNT(OC), .LATENCY(L)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .sel(sel), .in(din),
      .out(dout), .out_valid(ov)
`ifdef DEMUX_PIPELINE_DROP_COUNT_EN
      , .drop_count(dc)
`endif
   );

   demux_pipeline #(.WIDTH(W), .OUTPUT_COUNT(OC), .LATENCY(5)) dut5 (
      .clk(clk), .rst(rst), .in_valid(v5), .sel(sel5), .in(din5),
      .out(dout5), .out_valid(ov5)
`ifdef DEMUX_PIPELINE_DROP_COUNT_EN
      , .drop_count(dc5)
`endif
   );

   demux_pipeline #(.WIDTH(W), .OUTPUT_COUNT(1), .LATENCY(5)) dutb (
      .clk(clk), .rst(rst), .in_valid(vb), .sel(selb), .in(dinb),
      .out(doutb), .out_valid(ovb)
`ifdef DEMUX_PIPELINE_DROP_COUNT_EN
      , .drop_count(dcb)
`endif
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   logic rst_smp = 1'b1;
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rst_smp <= rst;
   end

   typedef struct {
      int         due;
      int         lane;
      logic [W-1:0] data;
      bit         drop;
   } exp_t;

   exp_t        q[$];
   logic [W-1:0] lanes [OC];
   int          edc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < OC; i++) lanes[i] = '0;
   end

   always @(negedge clk) begin : monitor
      logic [OC-1:0]   eov;
      logic [W*OC-1:0] eout;
      exp_t            it;
      eov = '0;
      if (rst_smp) begin
         for (int i = 0; i < OC; i++) lanes[i] = '0;
         edc = 0;
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         it = q.pop_front();
         if (it.due != cyc) chk("late_item", 64'(it.due), 64'(cyc));
         if (it.drop) edc++;
         else begin
            eov[it.lane] = 1'b1;
            lanes[it.lane] = it.data;
         end
      end
      for (int i = 0; i < OC; i++) eout[i*W +: W] = lanes[i];
      chk("out_valid", 64'(ov), 64'(eov));
      chk("out", 64'(dout), 64'(eout));
`ifdef DEMUX_PIPELINE_DROP_COUNT_EN
      chk("drop_count", 64'(dc), 64'(edc));
`endif
   end

   // Drive a beat that the next edge samples; exp_drop is the hand-derived out-of-range verdict.
   task automatic beat(input int s, input int d, input bit exp_drop);
      in_valid = 1'b1;
      sel = SW'(s);
      din = W'(d);
      if (!rst) q.push_back('{cyc + L, s, W'(d), exp_drop});
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic assert_rst();
      rst = 1'b1;
      while (q.size() > 0 && q[q.size()-1].due > cyc) q.delete(q.size() - 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // single beat to lane 3
      beat(3, 4'h5, 1'b0);
      idle(3);
      chk("lane3_hold", 64'(dout[3*W +: W]), 64'h5);

      // stream one beat per lane
      for (int i = 0; i < OC; i++) beat(i, i, 1'b0);
      idle(3);
      for (int i = 0; i < OC; i++) chk("stream_lane", 64'(dout[i*W +: W]), 64'(i));

      // out-of-range beats
      beat(12, 4'hA, 1'b1);
      idle(3);
      beat(10, 4'h1, 1'b1);
      beat(13, 4'h2, 1'b1);
      beat(15, 4'h3, 1'b1);
      idle(3);
`ifdef DEMUX_PIPELINE_DROP_COUNT_EN
      chk("drop_total", 64'(dc), 64'd4);
`endif

      // back-to-back beats to one lane
      beat(6, 4'h1, 1'b0);
      beat(6, 4'h2, 1'b0);
      beat(6, 4'h3, 1'b0);
      idle(3);

      // reset kills an in-flight beat; the first beat after release emerges
      beat(7, 4'h9, 1'b0);
      assert_rst();
      @(posedge clk); #1;
      rst = 1'b0;
      beat(7, 4'h2, 1'b0);
      idle(3);
      chk("post_rst_lane7", 64'(dout[7*W +: W]), 64'h2);

      // idle with random sel/in
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b0;
         sel = SW'($urandom_range(15, 0));
         din = W'($urandom_range(15, 0));
         @(posedge clk); #1;
      end

      // LATENCY=5: lane 9 of the 10-lane copy and lane 0 of the 1-lane copy
      v5 = 1'b1; sel5 = 4'd9; din5 = 4'hF;
      vb = 1'b1; selb = 1'b0; dinb = 4'h6;
      @(posedge clk); #1;
      v5 = 1'b0; vb = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk("l5_ov", 64'(ov5), (k == 5) ? 64'h200 : 64'h0);
         chk("l5_one_ov", 64'(ovb), (k == 5) ? 64'h1 : 64'h0);
      end
      chk("l5_lane9", 64'(dout5[9*W +: W]), 64'hF);
      chk("l5_one_lane", 64'(doutb), 64'h6);

      // single-lane copy: sel=1 is out of range
      @(posedge clk); #1;
      vb = 1'b1; selb = 1'b1; dinb = 4'h3;
      @(posedge clk); #1;
      vb = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk("l5_one_drop_ov", 64'(ovb), 64'h0);
      end
      chk("l5_one_hold", 64'(doutb), 64'h6);
`ifdef DEMUX_PIPELINE_DROP_COUNT_EN
      chk("l5_one_drops", 64'(dcb), 64'd1);
`endif

      begin
         int budget;
         budget = 20;
         while (q.size() > 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
         end
         chk("scoreboard_drained", 64'(q.size()), 64'd0);
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
